rs485_responder: RTL
====================

# rs485_responder

Half-duplex RS485 slave endpoint: the device at the far end of the bus from the SoC's RS485 master peripheral. It receives 8N1 request frames, decodes address/command/checksum, and executes reads or writes on a local 4×8-bit register bank. For unicast requests it turns the line around, drives DE and transmits a 4-byte response. Used as a bus-side test partner and as a remote-node building block.

## Interface
- CLK_DIV, default 16: clk_i cycles per oversample tick; 16 ticks = 1 bit; legal range ≥2.
- DEV_ADDR, default 8'h01: unicast address; must be non-zero.
- TURN_BITS, default 2: bit-times of silence, DE low, between request stop bit and DE assertion.
- TIMEOUT_BITS, default 32: inter-byte idle limit, in bit-times, before the parser resets.
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- rs485_rx_i  in  1  bus receive line; asynchronous, idle high.
- rs485_tx_o  out  1  bus transmit line; reset 1.
- rs485_de_o  out  1  driver enable; reset 0.
- regs_32b_o  out  32  register bank {r3,r2,r1,r0}; reset 0.
- wr_pulse_o  out  1  1-cycle strobe on register write; reset 0.
- wr_idx_2b_o  out  2  index of the written register; valid with wr_pulse_o; reset 0.
- frame_err_o  out  1  1-cycle strobe on framing, checksum or timeout error; reset 0.

## Operation
- Tick counter: free-running 0..CLK_DIV-1; a tick occurs on wrap.
- RX input: 2-FF synchronizer. Receiver is ignored (held in idle) while rs485_de_o=1.
- Receiver FSM: R_IDLE → R_START on a synchronized falling edge.
  - R_START: at tick 8, if line high, return to R_IDLE with no error (glitch); else go to R_DATA.
  - R_DATA: 8 bits, LSB first, each sampled 16 ticks apart.
  - R_STOP: stop bit sampled 16 ticks after bit 7. Stop=1 gives byte-valid; stop=0 raises frame_err_o and resets the parser.
- Request frame: [ADDR][CMD][DATA][CHK], CHK = ADDR^CMD^DATA.
  - CMD[7]=1 is a write; CMD[7]=0 is a read.
  - CMD[1:0] is the register index; CMD[6:2] is ignored but echoed.
- Parser FSM: P_ADDR → P_CMD → P_DATA → P_CHK, one state per valid byte.
- On CHK:
  - Checksum mismatch: frame_err_o, back to P_ADDR. Applies to matched and broadcast addresses.
  - ADDR ≠ DEV_ADDR and ≠ 0x00: silently discarded, back to P_ADDR. Non-matching frames are still tracked so byte alignment is kept.
  - ADDR = 0x00 (broadcast): writes execute, reads are ignored, no response.
  - ADDR = DEV_ADDR: the write executes if it is a write; then go to TURN.
- Write: the register updates on the clock edge that asserts wr_pulse_o, one cycle after the CHK byte-valid.
- Response frame: [DEV_ADDR][CMD][VAL][CHK].
  - VAL is the register value after the write, or the current value for a read.
  - CHK = DEV_ADDR^CMD^VAL.
- TX states:
  - TURN: DE=0 for TURN_BITS×16 ticks.
  - TX_LEAD: DE=1, tx=1 for 16 ticks.
  - TX_BYTE ×4: back-to-back 8N1 bytes, LSB first, 16 ticks per bit.
  - TX_TAIL: DE=1, tx=1 for 16 ticks.
  - Then DE=0, return to P_ADDR.
- Timeout: in P_CMD, P_DATA or P_CHK, if TIMEOUT_BITS×16 ticks pass with the receiver in R_IDLE, raise frame_err_o and return to P_ADDR.

## Timing
- Request decision: 1 clk after the CHK stop-bit sample.
- DE rises (TURN_BITS×16+1) ticks ±1 tick after the CHK stop-bit sample.
- First response start bit begins 16 ticks after DE rises.
- DE falls 16 ticks after the last stop bit ends.
- Total DE-high time = (1+40+1)×16 ticks.
- Pulse outputs are exactly 1 clk wide. frame_err_o and wr_pulse_o never assert in the same cycle.
- Asserting rst_i at any point (mid-byte, mid-response) forces tx=1, DE=0 and all FSMs to idle/P_ADDR, and clears the registers, immediately (async).
- Activity on rx during TURN or TX is ignored. No request is queued.

## Test plan
All scenarios use CLK_DIV=4, DEV_ADDR=8'h01, so 1 bit = 64 clk.
- Write r2=0x5A: send 01 82 5A D9 → wr_pulse_o with idx=2, regs_32b_o=0x005A0000 → response 01 82 5A D9. DE timing checked to ±1 tick.
- Read r2 after the write: send 01 02 00 03 → no wr_pulse_o; response 01 02 5A 59.
- Broadcast write r0=0x33: send 00 80 33 B3 → r0=0x33, wr_pulse_o; DE stays 0.
- Bad checksum: send 01 81 11 00 → frame_err_o, no register change, no DE. Then stop=0 on a byte → frame_err_o, and the parser accepts the next valid frame.
- Other address: send 07 83 44 C0 → no write, no response. A following 01-frame is answered correctly.
- Timeout: send 01 82 then idle 40 bit-times → frame_err_o once. Then send 5A D9 → treated as ADDR=5A and ignored. Also assert rst_i mid-response → tx=1, DE=0, regs=0.

Source files
------------

// File: rtl/rs485_responder.sv
// RS485 half-duplex slave: decodes [ADDR][CMD][DATA][CHK] requests against a 4x8 register bank
// and answers unicast requests with a 4-byte [DEV_ADDR][CMD][VAL][CHK] response after a turnaround gap.
module rs485_responder #(
    parameter int unsigned CLK_DIV      = 16,
    parameter logic [7:0]  DEV_ADDR     = 8'h01,
    parameter int unsigned TURN_BITS    = 2,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rs485_rx_i,
    output logic        rs485_tx_o,
    output logic        rs485_de_o,
    output logic [31:0] regs_32b_o,
    output logic        wr_pulse_o,
    output logic [1:0]  wr_idx_2b_o,
    output logic        frame_err_o
);
    localparam int unsigned DIV_W      = $clog2(CLK_DIV);
    localparam int unsigned TURN_TICKS = TURN_BITS * 16 + 1;
    localparam int unsigned PH_W       = $clog2(TURN_TICKS + 16);
    localparam int unsigned TO_TICKS   = TIMEOUT_BITS * 16;
    localparam int unsigned TO_W       = $clog2(TO_TICKS + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [2:0] {P_ADDR, P_CMD, P_DATA, P_CHK, P_TURN, P_LEAD, P_BYTE, P_TAIL} p_state_t;

    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    logic             rx_meta, rx_sync, rx_prev;

    r_state_t    r_state_q, r_state_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic [2:0]  r_bit_q, r_bit_d;
    logic [7:0]  r_shift_q, r_shift_d;
    logic        bv_q, bv_d, serr_q, serr_d;

    p_state_t    p_state_q, p_state_d;
    logic [7:0]  addr_q, addr_d, cmd_q, cmd_d, data_q, data_d;
    logic [31:0] regs_d, resp_q, resp_d;
    logic [9:0]  sh_q, sh_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic        tx_d, de_d, wr_d, ferr_d;
    logic [1:0]  widx_d;

    logic        rx_hold, rx_active, to_evt, hit, bcast, chk_ok;
    logic [7:0]  cur_val, val;

    // Oversample tick generator
    assign tick = (tick_cnt == DIV_W'(CLK_DIV - 1));
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
    end

    assign rx_hold   = (p_state_q inside {P_TURN, P_LEAD, P_BYTE, P_TAIL});
    assign rx_active = (p_state_q inside {P_CMD, P_DATA, P_CHK});
    assign to_evt    = rx_active && (r_state_q == R_IDLE) && !bv_q && tick
                       && (to_cnt_q == TO_W'(TO_TICKS - 1));
    assign hit       = (addr_q == DEV_ADDR);
    assign bcast     = (addr_q == 8'h00);
    assign chk_ok    = (r_shift_q == (addr_q ^ cmd_q ^ data_q));
    assign cur_val   = regs_32b_o[{cmd_q[1:0], 3'b000} +: 8];
    assign val       = cmd_q[7] ? data_q : cur_val;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            r_state_q   <= R_IDLE;
            r_cnt_q     <= '0;
            r_bit_q     <= '0;
            r_shift_q   <= '0;
            bv_q        <= 1'b0;
            serr_q      <= 1'b0;
            p_state_q   <= P_ADDR;
            addr_q      <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            regs_32b_o  <= '0;
            resp_q      <= '0;
            sh_q        <= '1;
            ph_q        <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            to_cnt_q    <= '0;
            rs485_tx_o  <= 1'b1;
            rs485_de_o  <= 1'b0;
            wr_pulse_o  <= 1'b0;
            wr_idx_2b_o <= '0;
            frame_err_o <= 1'b0;
        end else begin
            rx_meta     <= rs485_rx_i;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            r_state_q   <= r_state_d;
            r_cnt_q     <= r_cnt_d;
            r_bit_q     <= r_bit_d;
            r_shift_q   <= r_shift_d;
            bv_q        <= bv_d;
            serr_q      <= serr_d;
            p_state_q   <= p_state_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            regs_32b_o  <= regs_d;
            resp_q      <= resp_d;
            sh_q        <= sh_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            to_cnt_q    <= to_cnt_d;
            rs485_tx_o  <= tx_d;
            rs485_de_o  <= de_d;
            wr_pulse_o  <= wr_d;
            wr_idx_2b_o <= widx_d;
            frame_err_o <= ferr_d;
        end
    end

    // Receiver: start qualified at mid start bit, then one sample per 16 ticks
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_bit_d   = r_bit_q;
        r_shift_d = r_shift_q;
        bv_d      = 1'b0;
        serr_d    = 1'b0;
        if (rx_hold) begin
            r_state_d = R_IDLE;
        end else begin
            case (r_state_q)
                R_IDLE: if (rx_prev && !rx_sync) begin
                    r_state_d = R_START;
                    r_cnt_d   = '0;
                end
                R_START: if (tick) begin
                    r_cnt_d = r_cnt_q + 4'd1;
                    if (r_cnt_q == 4'd7) begin
                        r_cnt_d   = '0;
                        r_bit_d   = '0;
                        r_state_d = rx_sync ? R_IDLE : R_DATA;
                    end
                end
                R_DATA: if (tick) begin
                    r_cnt_d = r_cnt_q + 4'd1;
                    if (r_cnt_q == 4'd15) begin
                        r_shift_d = {rx_sync, r_shift_q[7:1]};
                        r_bit_d   = r_bit_q + 3'd1;
                        if (r_bit_q == 3'd7) r_state_d = R_STOP;
                    end
                end
                R_STOP: if (tick) begin
                    r_cnt_d = r_cnt_q + 4'd1;
                    if (r_cnt_q == 4'd15) begin
                        bv_d      = rx_sync;
                        serr_d    = !rx_sync;
                        r_state_d = R_IDLE;
                    end
                end
                default: r_state_d = R_IDLE;
            endcase
        end
    end

    // Parser, register bank and response transmitter
    always_comb begin
        p_state_d = p_state_q;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        regs_d    = regs_32b_o;
        resp_d    = resp_q;
        sh_d      = sh_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        to_cnt_d  = '0;
        wr_d      = 1'b0;
        widx_d    = wr_idx_2b_o;
        ferr_d    = 1'b0;
        if (rx_active && (r_state_q == R_IDLE) && !bv_q)
            to_cnt_d = tick ? to_cnt_q + TO_W'(1) : to_cnt_q;
        case (p_state_q)
            P_ADDR, P_CMD, P_DATA, P_CHK: begin
                if (serr_q) begin
                    ferr_d    = 1'b1;
                    p_state_d = P_ADDR;
                end else if (bv_q) begin
                    case (p_state_q)
                        P_ADDR: begin addr_d = r_shift_q; p_state_d = P_CMD;  end
                        P_CMD:  begin cmd_d  = r_shift_q; p_state_d = P_DATA; end
                        P_DATA: begin data_d = r_shift_q; p_state_d = P_CHK;  end
                        default: begin
                            p_state_d = P_ADDR;
                            if ((hit || bcast) && !chk_ok) begin
                                ferr_d = 1'b1;
                            end else if (hit || bcast) begin
                                if (cmd_q[7]) begin
                                    regs_d[{cmd_q[1:0], 3'b000} +: 8] = data_q;
                                    wr_d   = 1'b1;
                                    widx_d = cmd_q[1:0];
                                end
                                if (hit) begin
                                    resp_d    = {DEV_ADDR ^ cmd_q ^ val, val, cmd_q, DEV_ADDR};
                                    ph_d      = '0;
                                    p_state_d = P_TURN;
                                end
                            end
                        end
                    endcase
                end else if (to_evt) begin
                    ferr_d    = 1'b1;
                    p_state_d = P_ADDR;
                end
            end
            P_TURN: if (tick) begin
                ph_d = ph_q + PH_W'(1);
                if (ph_q == PH_W'(TURN_TICKS - 1)) begin
                    ph_d      = '0;
                    p_state_d = P_LEAD;
                end
            end
            P_LEAD: if (tick) begin
                ph_d = ph_q + PH_W'(1);
                if (ph_q == PH_W'(15)) begin
                    ph_d      = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    sh_d      = {1'b1, resp_q[7:0], 1'b0};
                    resp_d    = {8'h00, resp_q[31:8]};
                    p_state_d = P_BYTE;
                end
            end
            P_BYTE: if (tick) begin
                ph_d = ph_q + PH_W'(1);
                if (ph_q == PH_W'(15)) begin
                    ph_d = '0;
                    if (bit_q == 4'd9) begin
                        if (byte_q == 2'd3) begin
                            p_state_d = P_TAIL;
                        end else begin
                            byte_d = byte_q + 2'd1;
                            bit_d  = '0;
                            sh_d   = {1'b1, resp_q[7:0], 1'b0};
                            resp_d = {8'h00, resp_q[31:8]};
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sh_d  = {1'b1, sh_q[9:1]};
                    end
                end
            end
            P_TAIL: if (tick) begin
                ph_d = ph_q + PH_W'(1);
                if (ph_q == PH_W'(15)) begin
                    ph_d      = '0;
                    p_state_d = P_ADDR;
                end
            end
            default: p_state_d = P_ADDR;
        endcase
        de_d = (p_state_d inside {P_LEAD, P_BYTE, P_TAIL});
        tx_d = (p_state_d == P_BYTE) ? sh_d[0] : 1'b1;
    end
endmodule
